// File: rtl/codes.sv
// Shared CPU encodings: sequencer state and counter helpers.
package codes;

    localparam int unsigned CNT_W = 32;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC1  = 2'd1,
        EXEC2  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_W'(1);
    endfunction

endpackage

// File: rtl/stall_watchdog.sv
// Consecutive-stall watchdog: fires once the run of stall cycles reaches the
// threshold and keeps a sticky timeout flag until reset.
module stall_watchdog
    import codes::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic stall_i,
    output logic fire_c_o,
    output logic timeout_o
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(WATCHDOG_CYCLES);
    localparam logic             ENABLED = (WATCHDOG_CYCLES != 0);

    logic [CNT_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;
    logic             fire_c;

    // The edge that closes the WATCHDOG_CYCLES-th stall cycle is the one that halts.
    always_comb begin
        fire_c    = ENABLED & stall_i & (run_q == LIMIT - CNT_W'(1));
        run_d     = stall_i ? sat_inc(run_q) : '0;
        timeout_d = timeout_q | fire_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign fire_c_o  = fire_c;
    assign timeout_o = timeout_q;

endmodule

// File: rtl/cpu_sequencer.sv
// Multicycle FETCH/EXEC1/EXEC2 sequencer with halt detection, stall watchdog
// and retire/stall performance counters.
module cpu_sequencer
    import codes::*;
#(
    parameter int unsigned WATCHDOG_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             waitrequest_i,
    input  logic             ram_read_en_i,
    input  logic             ram_write_en_i,
    input  logic             muldiv_busy_i,
    input  logic [CNT_W-1:0] next_pc_i,
    output state_t           state_o,
    output logic             stall_o,
    output logic             active_o,
    output logic             retire_o,
    output logic [CNT_W-1:0] instr_count_o,
    output logic [CNT_W-1:0] stall_cycles_o,
    output logic             timeout_o
);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instr_q, instr_d;
    logic [CNT_W-1:0] stall_cyc_q, stall_cyc_d;

    logic mem_stall_c;
    logic md_stall_c;
    logic stall_c;
    logic advance_c;
    logic retire_c;
    logic wd_fire_c;

    stall_watchdog #(
        .WATCHDOG_CYCLES(WATCHDOG_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .rst_n    (rst_n),
        .stall_i  (stall_c),
        .fire_c_o (wd_fire_c),
        .timeout_o(timeout_o)
    );

    // A memory wait only matters when the decoder is actually accessing memory.
    always_comb begin
        mem_stall_c = waitrequest_i & (ram_read_en_i | ram_write_en_i);
        md_stall_c  = (state_q == EXEC2) & muldiv_busy_i;
        stall_c     = (state_q != HALTED) & (mem_stall_c | md_stall_c);
        advance_c   = ~stall_c & (state_q != HALTED);
    end

    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        case (state_q)
            FETCH: begin
                if (advance_c) state_d = EXEC1;
            end
            EXEC1: begin
                if (advance_c) state_d = EXEC2;
            end
            EXEC2: begin
                if (advance_c) begin
                    retire_c = 1'b1;
                    state_d  = (next_pc_i == '0) ? HALTED : FETCH;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
        // Watchdog expiry overrides whatever the sequencer wanted to do.
        if (wd_fire_c) state_d = HALTED;
    end

    always_comb begin
        instr_d     = retire_c ? instr_q + CNT_W'(1) : instr_q;
        stall_cyc_d = stall_c ? sat_inc(stall_cyc_q) : stall_cyc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FETCH;
            instr_q     <= '0;
            stall_cyc_q <= '0;
        end else begin
            state_q     <= state_d;
            instr_q     <= instr_d;
            stall_cyc_q <= stall_cyc_d;
        end
    end

    assign state_o        = state_q;
    assign stall_o        = stall_c;
    assign active_o       = (state_q != HALTED);
    assign retire_o       = retire_c;
    assign instr_count_o  = instr_q;
    assign stall_cycles_o = stall_cyc_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Self-checking bench for cpu_sequencer: directed vector table, hand-written
// corner sequences and randomized traffic against a cycle-level reference model.
module tb_cpu_sequencer;
    import codes::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        waitrequest;
    logic        rd_en;
    logic        wr_en;
    logic        busy;
    logic [31:0] next_pc;

    state_t      d_state, w_state;
    logic        d_stall, d_active, d_retire, d_timeout;
    logic        w_stall, w_active, w_retire, w_timeout;
    logic [31:0] d_instr, d_stallcyc, w_instr, w_stallcyc;

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0..2 = fetch/exec1/exec2, 3 = halted.
    localparam int MW = 1024;
    int          m_phase;
    int          m_run;
    logic [31:0] m_instr;
    logic [31:0] m_stallcyc;
    bit          m_timeout;

    always #5 clk = ~clk;

    cpu_sequencer u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .waitrequest_i (waitrequest),
        .ram_read_en_i (rd_en),
        .ram_write_en_i(wr_en),
        .muldiv_busy_i (busy),
        .next_pc_i     (next_pc),
        .state_o       (d_state),
        .stall_o       (d_stall),
        .active_o      (d_active),
        .retire_o      (d_retire),
        .instr_count_o (d_instr),
        .stall_cycles_o(d_stallcyc),
        .timeout_o     (d_timeout)
    );

    cpu_sequencer #(.WATCHDOG_CYCLES(4)) u_wd (
        .clk           (clk),
        .rst_n         (rst_n),
        .waitrequest_i (waitrequest),
        .ram_read_en_i (rd_en),
        .ram_write_en_i(wr_en),
        .muldiv_busy_i (busy),
        .next_pc_i     (next_pc),
        .state_o       (w_state),
        .stall_o       (w_stall),
        .active_o      (w_active),
        .retire_o      (w_retire),
        .instr_count_o (w_instr),
        .stall_cycles_o(w_stallcyc),
        .timeout_o     (w_timeout)
    );

    typedef struct {
        bit          wr;
        bit          rd;
        bit          we;
        bit          busy;
        logic [31:0] npc;
        state_t      st;
        bit          stall;
        bit          retire;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_stall();
        if (m_phase == 3) return 1'b0;
        return (waitrequest & (rd_en | wr_en)) | ((m_phase == 2) & busy);
    endfunction

    function automatic void model_reset();
        m_phase    = 0;
        m_run      = 0;
        m_instr    = 0;
        m_stallcyc = 0;
        m_timeout  = 1'b0;
    endfunction

    // Called at a negedge: apply inputs and let combinational outputs settle.
    task automatic drive(input bit wr, input bit rd, input bit we, input bit bz,
                         input logic [31:0] npc);
        waitrequest = wr;
        rd_en       = rd;
        wr_en       = we;
        busy        = bz;
        next_pc     = npc;
        #1;
    endtask

    task automatic model_check();
        bit s;
        s = exp_stall();
        chk("state", 32'(d_state), 32'(m_phase));
        chk("stall", 32'(d_stall), 32'(s));
        chk("retire", 32'(d_retire), 32'((m_phase == 2) && !s));
        chk("active", 32'(d_active), 32'(m_phase != 3));
        chk("instr_count", d_instr, m_instr);
        chk("stall_cycles", d_stallcyc, m_stallcyc);
        chk("timeout", 32'(d_timeout), 32'(m_timeout));
    endtask

    // Clock edge plus model update; returns at the following negedge.
    task automatic tick();
        bit s;
        s = exp_stall();
        @(posedge clk);
        if (rst_n && m_phase != 3) begin
            if (s) begin
                if (m_stallcyc != 32'hFFFF_FFFF) m_stallcyc++;
                m_run++;
                if (m_run == MW) begin
                    m_phase   = 3;
                    m_timeout = 1'b1;
                end
            end else begin
                m_run = 0;
                if (m_phase == 2) begin
                    m_instr++;
                    m_phase = (next_pc == 32'h0) ? 3 : 0;
                end else begin
                    m_phase++;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst_state", 32'(d_state), 32'(FETCH));
        chk("rst_instr", d_instr, 32'h0);
        chk("rst_stallcyc", d_stallcyc, 32'h0);
        chk("rst_timeout", 32'(d_timeout), 32'h0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic cyc(input bit wr, input bit rd, input bit we, input bit bz,
                       input logic [31:0] npc);
        drive(wr, rd, we, bz, npc);
        model_check();
        tick();
    endtask

    function automatic void add(input bit wr, input bit rd, input bit we, input bit bz,
                                input logic [31:0] npc, input state_t st,
                                input bit s, input bit r);
        vec_t v;
        v.wr = wr; v.rd = rd; v.we = we; v.busy = bz; v.npc = npc;
        v.st = st; v.stall = s; v.retire = r;
        tbl.push_back(v);
    endfunction

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 32'h4);
        model_reset();
        @(negedge clk);

        // Three unstalled instructions.
        for (int k = 0; k < 3; k++) begin
            add(0, 0, 0, 0, 32'h4, FETCH, 0, 0);
            add(0, 0, 0, 0, 32'h4, EXEC1, 0, 0);
            add(0, 0, 0, 0, 32'h4, EXEC2, 0, 1);
        end
        // Fetch waits two cycles, then exec1 ignores waitrequest without enables.
        add(1, 1, 0, 0, 32'h8, FETCH, 1, 0);
        add(1, 1, 0, 0, 32'h8, FETCH, 1, 0);
        add(0, 1, 0, 0, 32'h8, FETCH, 0, 0);
        add(1, 0, 0, 0, 32'h8, EXEC1, 0, 0);
        // Muldiv busy five cycles, two of them also memory-stalled.
        add(0, 0, 0, 1, 32'h8, EXEC2, 1, 0);
        add(1, 0, 1, 1, 32'h8, EXEC2, 1, 0);
        add(1, 0, 1, 1, 32'h8, EXEC2, 1, 0);
        add(0, 0, 0, 1, 32'h8, EXEC2, 1, 0);
        add(1, 0, 0, 1, 32'h8, EXEC2, 1, 0);
        add(1, 0, 0, 0, 32'h8, EXEC2, 0, 1);

        do_reset();
        foreach (tbl[i]) begin
            drive(tbl[i].wr, tbl[i].rd, tbl[i].we, tbl[i].busy, tbl[i].npc);
            chk($sformatf("tbl%0d_state", i), 32'(d_state), 32'(tbl[i].st));
            chk($sformatf("tbl%0d_stall", i), 32'(d_stall), 32'(tbl[i].stall));
            chk($sformatf("tbl%0d_retire", i), 32'(d_retire), 32'(tbl[i].retire));
            model_check();
            tick();
        end
        drive(0, 0, 0, 0, 32'h4);
        chk("tbl_instr", d_instr, 32'd4);
        chk("tbl_stallcyc", d_stallcyc, 32'd7);

        // Halt on jump to address zero.
        cyc(0, 0, 0, 0, 32'h4);
        cyc(0, 0, 0, 0, 32'h4);
        drive(0, 0, 0, 0, 32'h0);
        chk("halt_retire", 32'(d_retire), 32'h1);
        model_check();
        tick();
        drive(0, 0, 0, 0, 32'h0);
        chk("halt_state", 32'(d_state), 32'(HALTED));
        chk("halt_active", 32'(d_active), 32'h0);
        chk("halt_instr", d_instr, 32'd5);
        for (int k = 0; k < 6; k++)
            cyc(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), $urandom);
        chk("halt_frozen", d_instr, 32'd5);

        // Asynchronous reset landing in EXEC1 with seven retired.
        do_reset();
        for (int k = 0; k < 21; k++) cyc(0, 0, 0, 0, 32'h10);
        cyc(0, 0, 0, 0, 32'h10);
        drive(0, 0, 0, 0, 32'h10);
        chk("pre_rst_state", 32'(d_state), 32'(EXEC1));
        chk("pre_rst_instr", d_instr, 32'd7);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_state", 32'(d_state), 32'(FETCH));
        chk("async_rst_instr", d_instr, 32'h0);
        chk("async_rst_retire", 32'(d_retire), 32'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Watchdog (threshold 4): interrupted runs do not fire.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 0, 0, 32'h4);
            @(posedge clk);
            @(negedge clk);
        end
        drive(0, 1, 0, 0, 32'h4);
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 1, 0, 32'h4);
            @(posedge clk);
            @(negedge clk);
        end
        drive(1, 0, 1, 0, 32'h4);
        chk("wd_clear_state", 32'(w_state), 32'(EXEC1));
        chk("wd_clear_timeout", 32'(w_timeout), 32'h0);
        chk("wd_clear_stallcyc", w_stallcyc, 32'd6);

        // Watchdog stuck fetch: halts exactly after the fourth stall cycle.
        do_reset();
        drive(1, 1, 0, 0, 32'h4);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("wd3_state", 32'(w_state), 32'(FETCH));
        chk("wd3_timeout", 32'(w_timeout), 32'h0);
        chk("wd3_stall", 32'(w_stall), 32'h1);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("wd_state", 32'(w_state), 32'(HALTED));
        chk("wd_timeout", 32'(w_timeout), 32'h1);
        chk("wd_stallcyc", w_stallcyc, 32'd4);
        chk("wd_stall_halted", 32'(w_stall), 32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("wd_frozen", w_stallcyc, 32'd4);
        chk("wd_active", 32'(w_active), 32'h0);
        @(negedge clk);

        // Randomized traffic against the model.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            if (m_phase == 3 && $urandom_range(0, 3) == 0) begin
                do_reset();
            end else begin
                cyc(($urandom_range(0, 9) < 3), 1'($urandom), 1'($urandom),
                    ($urandom_range(0, 9) < 3),
                    ($urandom_range(0, 63) == 0) ? 32'h0 : ($urandom | 32'h4));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle state sequencer for the MIPS CPU. It produces the `state_t` value and the `stall` signal that the control decoder consumes. It advances FETCH→EXEC1→EXEC2 per instruction and holds on Avalon `waitrequest` or a busy multiply/divide unit. It also detects program halt (jump to address 0), runs a stall watchdog, and keeps retire/stall performance counters.

## Interface
Parameters:
- `WATCHDOG_CYCLES`, default 1024: consecutive stall cycles before forced halt. 0 disables the watchdog.

Ports:
- `clk`  in  1  single system clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `waitrequest_i`  in  1  Avalon waitrequest from memory.
- `ram_read_en_i`  in  1  read enable currently driven by the control decoder.
- `ram_write_en_i`  in  1  write enable currently driven by the control decoder.
- `muldiv_busy_i`  in  1  multiply/divide unit still computing.
- `next_pc_i`  in  32  PC value to be written at the end of EXEC2.
- `state_o`  out  `state_t`  current state: FETCH, EXEC1, EXEC2 or HALTED.
- `stall_o`  out  1  current cycle must not advance.
- `active_o`  out  1  CPU not halted.
- `retire_o`  out  1  one-cycle pulse: the instruction completes this cycle.
- `instr_count_o`  out  32  retired instruction count.
- `stall_cycles_o`  out  32  total stall cycles.
- `timeout_o`  out  1  sticky watchdog-fired flag.

## Operation
- `stall_o = (waitrequest_i & (ram_read_en_i | ram_write_en_i)) | (state_o==EXEC2 & muldiv_busy_i)`. Purely combinational. Forced to 0 in HALTED.
- `advance = ~stall_o & state_o != HALTED`.
- Transitions, all gated by `advance`:
  - FETCH→EXEC1.
  - EXEC1→EXEC2.
  - EXEC2→FETCH, or EXEC2→HALTED if `next_pc_i == 32'h0`.
  - HALTED is terminal until reset.
- `retire_o = (state_o==EXEC2) & advance`. It pulses on the halting instruction too.
- `instr_count_o` increments on `retire_o` and wraps 0xFFFF_FFFF→0.
- `stall_cycles_o` increments on each cycle with `stall_o=1` and saturates at 0xFFFF_FFFF.
- Watchdog:
  - An internal consecutive-stall counter increments while `stall_o=1` and clears on any non-stall cycle.
  - When it reaches `WATCHDOG_CYCLES` (≠0), the next edge sets `timeout_o=1` and state HALTED, regardless of the current state.
  - Watchdog expiry takes priority over a simultaneous advance.
- `active_o = (state_o != HALTED)`.

## Timing
- Reset values, applied immediately on `rst_n` low (asynchronous):
  - `state_o=FETCH`, so `active_o=1`.
  - `instr_count_o=0`, `stall_cycles_o=0`, `timeout_o=0`.
  - Watchdog counter 0.
  - `retire_o=0`, `stall_o` as derived.
- Reset mid-instruction abandons the instruction with no retire. The first edge after release still evaluates from FETCH.
- Unstalled throughput: 3 cycles per instruction; `retire_o` every third cycle.
- A state holds for exactly N extra cycles when `stall_o` is high for N cycles. The transition occurs on the first edge with `stall_o=0`.
- `waitrequest_i` with both enables low does not stall. This applies in EXEC1 for non-loads and in EXEC2 for non-stores.
- EXEC2 with both a memory stall and `muldiv_busy_i` high counts one stall cycle, not two.
- In HALTED, counters freeze, `stall_o=0` and `retire_o=0`.

## Structure
- `state_t` lives in the shared `codes` package, which is extended with a HALTED encoding.
- Sub-module `stall_watchdog` contains the consecutive counter, the threshold compare and the sticky `timeout_o`, parameterised by `WATCHDOG_CYCLES`.
- The sequencer FSM and the performance counters stay in `cpu_sequencer`.

## Test plan
- Release reset, no stalls, `next_pc_i` nonzero for 3 instructions:
  - states F,E1,E2 repeat;
  - `retire_o` high in cycles 3, 6 and 9;
  - `instr_count_o=3`.
- FETCH with `ram_read_en_i=1` and `waitrequest_i` high for 2 cycles:
  - FETCH held 3 cycles;
  - `stall_o` high 2 cycles;
  - `stall_cycles_o=2`;
  - then EXEC1.
- EXEC2 with `muldiv_busy_i` high for 5 cycles: EXEC2 held 6 cycles, `retire_o` pulses once, `stall_cycles_o=5`.
- EXEC2 advance with `next_pc_i=0`:
  - `retire_o=1` and `instr_count_o` +1;
  - next cycle HALTED with `active_o=0`;
  - further stimulus changes nothing.
- `WATCHDOG_CYCLES=4` with `waitrequest_i` stuck high and `ram_read_en_i=1` in FETCH: after 4 stall cycles, `timeout_o=1`, HALTED, `stall_cycles_o=4`.
- Assert `rst_n` low in EXEC1 with `instr_count_o=7`: `state_o=FETCH` and counters 0 immediately, before any clock edge.
